// File: rtl/shift_rx.sv
//------------------------------------------------------------------------------
// shift_rx : serial-to-parallel receiver, MSB first, valid/ack delivery with
//            sticky framing (err_len) and overrun (ovr) flags.
// Optional : define SHIFT_RX_PARITY_EN for a trailing even-parity bit + perr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_rx #(
   parameter int bits = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sin,
   input  logic            en,
   input  logic            eos,
   output logic [bits-1:0] Q,
   output logic            valid,
   input  logic            ack,
   output logic            busy,
   output logic            err_len,
   output logic            ovr,
`ifdef SHIFT_RX_PARITY_EN
   output logic            perr,
`endif
   input  logic            clr_err
);

`ifdef SHIFT_RX_PARITY_EN
   localparam int FL = bits + 1;
`else
   localparam int FL = bits;
`endif
   localparam int CW = $clog2(FL + 1);
   localparam logic [CW-1:0] LAST = CW'(FL - 1);

   typedef enum logic {S_IDLE, S_RECV} state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [bits-1:0]   sr_q;
   logic [bits-1:0]   shift_d;
   logic [bits-1:0]   word_d;
   logic              last_bit;

   always_comb begin
      shift_d = {sr_q[bits-2:0], sin};
`ifdef SHIFT_RX_PARITY_EN
      // the parity bit arrives last and is never part of the word
      word_d  = sr_q;
`else
      word_d  = shift_d;
`endif
      last_bit = (cnt_q == LAST);
   end

   assign busy = (state_q == S_RECV);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         Q       <= '0;
         valid   <= 1'b0;
         err_len <= 1'b0;
         ovr     <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
         perr    <= 1'b0;
`endif
      end else begin
         // clears come first so that a same-cycle error set takes priority
         if (clr_err) begin
            err_len <= 1'b0;
            ovr     <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
            perr    <= 1'b0;
`endif
         end
         if (ack) valid <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (en) begin
                  if (eos) begin
                     err_len <= 1'b1;
                  end else begin
                     sr_q    <= shift_d;
                     cnt_q   <= CW'(1);
                     state_q <= S_RECV;
                  end
               end
            end
            S_RECV: begin
               if (!en) begin
                  err_len <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  sr_q  <= shift_d;
                  cnt_q <= cnt_q + CW'(1);
                  if (eos || last_bit) state_q <= S_IDLE;
                  if (eos && last_bit) begin
`ifdef SHIFT_RX_PARITY_EN
                     if (^{sr_q, sin}) begin
                        perr <= 1'b1;
                     end else if (valid && !ack) begin
                        ovr <= 1'b1;
                     end else begin
                        Q     <= word_d;
                        valid <= 1'b1;
                     end
`else
                     if (valid && !ack) begin
                        ovr <= 1'b1;
                     end else begin
                        Q     <= word_d;
                        valid <= 1'b1;
                     end
`endif
                  end else if (eos || last_bit) begin
                     err_len <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_shift_rx.sv
//------------------------------------------------------------------------------
// tb_shift_rx : directed self-checking bench for shift_rx (bits = 8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_rx;
   localparam int BITS = 8;
`ifdef SHIFT_RX_PARITY_EN
   localparam int FL = BITS + 1;
`else
   localparam int FL = BITS;
`endif

   logic            clk = 1'b0;
   logic            rst, sin, en, eos, ack, clr_err;
   logic [BITS-1:0] Q;
   logic            valid, busy, err_len, ovr;
`ifdef SHIFT_RX_PARITY_EN
   logic            perr;
`endif

   int n_vec = 0;
   int n_err = 0;

   shift_rx #(.bits(BITS)) dut (
      .clk(clk), .rst(rst), .sin(sin), .en(en), .eos(eos),
      .Q(Q), .valid(valid), .ack(ack), .busy(busy),
      .err_len(err_len), .ovr(ovr),
`ifdef SHIFT_RX_PARITY_EN
      .perr(perr),
`endif
      .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // frame bit vector: data word, plus even parity bit when enabled
   function automatic logic [32:0] fv(input logic [7:0] w);
`ifdef SHIFT_RX_PARITY_EN
      return {24'd0, w, ^w};
`else
      return {25'd0, w};
`endif
   endfunction

   // send v[n-1:0] MSB first; am: 0 no ack, 1 ack on last bit, 2 ack every bit
   task automatic send(input logic [32:0] v, input int n, input logic e, input int am);
      for (int i = 0; i < n; i++) begin
         en  = 1'b1;
         sin = v[n-1-i];
         eos = e && (i == n-1);
         ack = (am == 2) || (am == 1 && i == n-1);
         tick();
      end
      en = 1'b0; sin = 1'b0; eos = 1'b0; ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sin = 1'b0; en = 1'b0; eos = 1'b0; ack = 1'b0; clr_err = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_Q", 32'(Q), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err_len", 32'(err_len), 32'h0);
      chk("rst_ovr", 32'(ovr), 32'h0);

      // normal frame
      send(fv(8'hA5), FL, 1'b1, 0);
      chk("norm_Q", 32'(Q), 32'hA5);
      chk("norm_valid", 32'(valid), 32'h1);
      chk("norm_busy", 32'(busy), 32'h0);
      chk("norm_err_len", 32'(err_len), 32'h0);
      chk("norm_ovr", 32'(ovr), 32'h0);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("ack_valid", 32'(valid), 32'h0);
      chk("ack_Q", 32'(Q), 32'hA5);

      // short frame
      send(33'h15, 5, 1'b1, 0);
      chk("short_err_len", 32'(err_len), 32'h1);
      chk("short_valid", 32'(valid), 32'h0);
      chk("short_busy", 32'(busy), 32'h0);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("clr_err_len", 32'(err_len), 32'h0);

      // clear and a new error on the same cycle: set wins
      clr_err = 1'b1;
      send(33'h5, 3, 1'b1, 0);
      clr_err = 1'b0;
      chk("setwins_err_len", 32'(err_len), 32'h1);
      clr_err = 1'b1; tick(); clr_err = 1'b0;

      // gap abort then recovery
      send(33'h5, 3, 1'b0, 0);
      chk("gap_busy_mid", 32'(busy), 32'h1);
      tick();
      chk("gap_err_len", 32'(err_len), 32'h1);
      chk("gap_busy", 32'(busy), 32'h0);
      send(fv(8'h3C), FL, 1'b1, 0);
      chk("rec_Q", 32'(Q), 32'h3C);
      chk("rec_valid", 32'(valid), 32'h1);
      ack = 1'b1; clr_err = 1'b1; tick(); ack = 1'b0; clr_err = 1'b0;
      chk("rec_clr_err", 32'(err_len), 32'h0);

      // long frame: no eos on the last bit
      send(fv(8'h0F), FL, 1'b0, 0);
      chk("long_err_len", 32'(err_len), 32'h1);
      chk("long_busy", 32'(busy), 32'h0);
      chk("long_valid", 32'(valid), 32'h0);
      clr_err = 1'b1; tick(); clr_err = 1'b0;

      // overrun
      send(fv(8'h11), FL, 1'b1, 0);
      send(fv(8'h22), FL, 1'b1, 0);
      chk("ovr_Q", 32'(Q), 32'h11);
      chk("ovr_valid", 32'(valid), 32'h1);
      chk("ovr_flag", 32'(ovr), 32'h1);
      ack = 1'b1; clr_err = 1'b1; tick(); ack = 1'b0; clr_err = 1'b0;
      chk("ovr_clr", 32'(ovr), 32'h0);
      send(fv(8'h11), FL, 1'b1, 0);
      send(fv(8'h22), FL, 1'b1, 1);
      chk("ackovr_Q", 32'(Q), 32'h22);
      chk("ackovr_valid", 32'(valid), 32'h1);
      chk("ackovr_flag", 32'(ovr), 32'h0);
      ack = 1'b1; tick(); ack = 1'b0;

      // back-to-back frames with ack held high
      send(fv(8'hFF), FL, 1'b1, 2);
      chk("b2b_Q1", 32'(Q), 32'hFF);
      chk("b2b_valid1", 32'(valid), 32'h1);
      send(fv(8'h00) >> (FL - 1), 1, 1'b0, 2);
      chk("b2b_valid_gap", 32'(valid), 32'h0);
      chk("b2b_busy", 32'(busy), 32'h1);
      send(fv(8'h00), FL - 1, 1'b1, 2);
      chk("b2b_Q2", 32'(Q), 32'h00);
      chk("b2b_valid2", 32'(valid), 32'h1);
      chk("b2b_err_len", 32'(err_len), 32'h0);
      chk("b2b_ovr", 32'(ovr), 32'h0);

      // reset mid-frame (valid is still high from the previous frame)
      send(fv(8'hC3) >> (FL - 4), 4, 1'b0, 0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mrst_Q", 32'(Q), 32'h0);
      chk("mrst_valid", 32'(valid), 32'h0);
      chk("mrst_busy", 32'(busy), 32'h0);
      chk("mrst_err_len", 32'(err_len), 32'h0);
      send(fv(8'h81), FL, 1'b1, 0);
      chk("mrst_Q81", 32'(Q), 32'h81);
      chk("mrst_valid81", 32'(valid), 32'h1);
      chk("mrst_err81", 32'(err_len), 32'h0);
      ack = 1'b1; tick(); ack = 1'b0;

`ifdef SHIFT_RX_PARITY_EN
      send({24'd0, 8'hA5, 1'b0}, FL, 1'b1, 0);
      chk("par_ok_Q", 32'(Q), 32'hA5);
      chk("par_ok_valid", 32'(valid), 32'h1);
      chk("par_ok_perr", 32'(perr), 32'h0);
      ack = 1'b1; tick(); ack = 1'b0;
      send({24'd0, 8'hA5, 1'b1}, FL, 1'b1, 0);
      chk("par_bad_perr", 32'(perr), 32'h1);
      chk("par_bad_valid", 32'(valid), 32'h0);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("par_clr", 32'(perr), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
